fetch_sequencer: RTL

Controller that sequences the instruction-fetch datapath of the RISC-V core. It owns the PC and issues requests to instruction memory over a req/ack handshake. It buffers one fetched instruction toward decode with a valid/ready handshake. It applies branch/jump redirects, trap vectoring and fetch-timeout faults.

---
 rtl/fetch_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives the imem req/ack fetch and holds one instruction for decode
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    output logic        fetch_fault
);
    localparam int W = $clog2(MAX_WAIT) + 1;
    localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t       state;
    logic [31:0]  pc;
    logic [W-1:0] wait_cnt;
    logic         timeout;
    logic         aligned;

    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign timeout   = imem_req && !imem_ack && wait_cnt == LAST;
    assign aligned   = redirect_pc[1:0] == 2'b00;

    // Controls win over the datapath in order trap > timeout > redirect; any of them
    // drops into IDLE so the outstanding memory access is cancelled and its ack lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            instr_valid <= 1'b0;
            instr_code  <= '0;
            instr_pc    <= '0;
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= 1'b0;
            if (trap) begin
                pc          <= TRAP_VEC;
                instr_valid <= 1'b0;
                wait_cnt    <= '0;
                state       <= IDLE;
            end else if (timeout) begin
                pc          <= TRAP_VEC;
                fetch_fault <= 1'b1;
                wait_cnt    <= '0;
                state       <= IDLE;
            end else if (redirect_valid) begin
                pc          <= aligned ? redirect_pc : TRAP_VEC;
                fetch_fault <= !aligned;
                instr_valid <= 1'b0;
                wait_cnt    <= '0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end
                    FETCH: begin
                        if (imem_ack) begin
                            instr_code  <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + 32'd4;
                            state       <= HOLD;
                        end else begin
                            wait_cnt <= &wait_cnt ? wait_cnt : wait_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            wait_cnt    <= '0;
                            state       <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
